// File: rtl/mips150_fetch_pkg.sv
// Shared MIPS150 fetch-stage definitions: NOP encoding, reset PC, RAM width, FSM states.
// No logic; constants and types only.
// Imported by the fetch interface, the fetch stage and its testbench.
package mips150_fetch_pkg;

    localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [31:0] MIPS150_RESET_PC = 32'h4000_0000;
    localparam int          MIPS150_ADDR_W   = 12;

    // RUN: decode sees the RAM output directly; HOLD: decode sees the captured word.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/mips150_fetch_if.sv
// Fetch-stage bus: decode control in, instruction RAM port, decode-facing results out.
// Pure wiring, zero latency.
// Stall/redirect come from the consumer side; the fetch stage honours them every cycle.
interface mips150_fetch_if
    import mips150_fetch_pkg::*;
#(
    parameter int ADDR_W = MIPS150_ADDR_W
) ();

    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_dout;
    logic [31:0]       instr_d;
    logic [31:0]       pc_d;
    logic [31:0]       pc_plus4_d;
    logic              valid_d;
    logic              fetch_fault;

    // Fetch stage side.
    modport master (
        input  stall, redirect, redirect_pc, imem_dout,
        output imem_en, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault
    );

    // Decode stage plus instruction RAM side.
    modport slave (
        output stall, redirect, redirect_pc, imem_dout,
        input  imem_en, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault
    );

endinterface

// File: rtl/mips150_fetch.sv
// MIPS150 instruction fetch: PC register, sync-read instruction RAM driver, decode hand-off.
// Latency: 1 cycle fetch-to-decode, 1 instruction/cycle sustained.
// Stall holds the decode word (captured into a hold register); redirect overrides stall.
module mips150_fetch
    import mips150_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MIPS150_RESET_PC,
    parameter int          ADDR_W   = MIPS150_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    mips150_fetch_if.master fetch_bus
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pc_dec_q, pc_dec_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_hold_q, instr_hold_d;
    logic         fault_q, fault_d;
    fetch_state_e state_q, state_d;

    // Next-PC mux and FSM transitions: redirect beats stall, stall beats advance.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pc_dec_d     = pc_dec_q;
        valid_d      = valid_q;
        instr_hold_d = instr_hold_q;
        fault_d      = fault_q;
        state_d      = state_q;
        if (fetch_bus.redirect) begin
            // The word already addressed is the delay slot and is delivered to decode.
            fetch_pc_d = {fetch_bus.redirect_pc[31:2], 2'b00};
            pc_dec_d   = fetch_pc_q;
            valid_d    = 1'b1;
            state_d    = ST_RUN;
            if (fetch_bus.redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end else if (fetch_bus.stall) begin
            // Capture only on entry to HOLD; later stall cycles leave the copy alone.
            if (state_q == ST_RUN) begin
                instr_hold_d = fetch_bus.imem_dout;
                state_d      = ST_HOLD;
            end
        end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pc_dec_d   = fetch_pc_q;
            valid_d    = 1'b1;
            state_d    = ST_RUN;
        end
    end

    // State and registered outputs; async reset discards any in-flight stall or redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            pc_dec_q     <= 32'h0;
            valid_q      <= 1'b0;
            instr_hold_q <= 32'h0;
            fault_q      <= 1'b0;
            state_q      <= ST_RUN;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pc_dec_q     <= pc_dec_d;
            valid_q      <= valid_d;
            instr_hold_q <= instr_hold_d;
            fault_q      <= fault_d;
            state_q      <= state_d;
        end
    end

    // A redirect must issue the delay-slot read even while decode is stalled.
    assign fetch_bus.imem_en     = !fetch_bus.stall || fetch_bus.redirect;
    assign fetch_bus.imem_addr   = fetch_pc_q[ADDR_W+1:2];
    assign fetch_bus.instr_d     = !valid_q             ? MIPS_NOP :
                                   (state_q == ST_HOLD) ? instr_hold_q : fetch_bus.imem_dout;
    assign fetch_bus.pc_d        = pc_dec_q;
    assign fetch_bus.pc_plus4_d  = pc_dec_q + 32'd4;
    assign fetch_bus.valid_d     = valid_q;
    assign fetch_bus.fetch_fault = fault_q;

endmodule
